digit_sampler: RTL and testbench
================================

DIGIT_SAMPLER -- requirements
Module: digit_sampler

Interface
REQ-001 SHALL have parameter IMG_W, default 320, framebuffer line width in pixels.
REQ-002 SHALL have parameter IMG_H, default 240, framebuffer height in lines.
REQ-003 SHALL have parameter X0, default 48, crop window left column.
REQ-004 SHALL have parameter Y0, default 8, crop window top line.
REQ-005 SHALL have parameter RD_LATENCY, default 2, framebuffer read latency in cycles (1..4).
REQ-006 SHALL have port Clk  input  1  single clock; framebuffer rdclock is driven from the same clock.
REQ-007 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port start  input  1  one-cycle request to sample a frame.
REQ-009 SHALL have port busy  output  1  high from accepted start until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse after the last pixel is accepted.
REQ-011 SHALL have port rdaddress  output  17  framebuffer read address, row-major y*IMG_W+x.
REQ-012 SHALL have port q  input  8  framebuffer read data, valid RD_LATENCY cycles after its address.
REQ-013 SHALL have port pix_data  output  8  downsampled pixel.
REQ-014 SHALL have port pix_index  output  10  output pixel index 0..783, row-major r*28+c.
REQ-015 SHALL have port pix_valid  output  1  pix_data/pix_index valid.
REQ-016 SHALL have port pix_ready  input  1  consumer accepts when pix_valid and pix_ready are both high.

Function
REQ-017 SHALL reduce the 224x224 window at (X0,Y0) to 28x28 by averaging each 8x8 block: block (r,c) covers x=X0+8c+dx, y=Y0+8r+dy, dx,dy in 0..7.
REQ-018 SHALL compute pix_data = (sum+32)>>6 with a 14-bit sum; no saturation needed (max 255).
REQ-019 SHALL implement states IDLE, READ, DRAIN, OUT, DONE.
REQ-020 IDLE: start=1 -> READ, clear accumulator, r=c=0; rdaddress=0.
REQ-021 READ: issue one address per cycle, dx fastest then dy, 64 cycles, then DRAIN.
REQ-022 DRAIN: wait RD_LATENCY cycles while the last q values accumulate, then OUT.
REQ-023 SHALL accumulate q exactly once per issued address, tracked by a RD_LATENCY-deep valid shift register.
REQ-024 OUT: hold pix_valid, pix_data, pix_index stable until handshake; on handshake, last block -> DONE, else advance c (wrap to 0, r+1 at c=27), clear accumulator -> READ.
REQ-025 DONE: done=1 for one cycle -> IDLE.
REQ-026 First pix_valid SHALL assert 1+64+RD_LATENCY cycles after the start edge; no reads issued in OUT.
REQ-027 start while busy SHALL be ignored.
REQ-028 busy SHALL be 1 in READ, DRAIN, OUT, DONE.

Reset
REQ-029 Reset SHALL immediately force IDLE, busy=0, done=0, pix_valid=0, pix_data=0, pix_index=0, rdaddress=0, accumulator and pipeline cleared.
REQ-030 Reset mid-frame SHALL abandon the frame with no done pulse; next start begins at block 0.

Configuration
REQ-031 With DIGIT_SAMPLER_INVERT_EN defined, pix_data SHALL be 255 minus the rounded average (white-on-black digits); without it, the plain rounded average.

Verification
REQ-032 Constant frame q=100, pix_ready=1 -> 784 pixels, all 100 (155 with DIGIT_SAMPLER_INVERT_EN), indices 0..783 in order, one done pulse.
REQ-033 Frame pixel=x&0xFF, defaults -> pixel (r,c) = 52+8c, independent of r.
REQ-034 pix_ready low 10 cycles on pixel 5 -> pix_valid/data/index held, rdaddress static, no pixel lost or duplicated.
REQ-035 Pulse start at cycle 20 of a frame -> ignored, frame completes normally with 784 pixels.
REQ-036 Reset asserted mid-READ of pixel 300 -> all outputs zero immediately, no done; subsequent start delivers index 0 first.
REQ-037 RD_LATENCY=1 and 4, constant frame 37 -> all pixels 37; first pix_valid at start+66 and start+69.

Source files
------------

// File: rtl/digit_sampler.sv
// Downsamples a 224x224 framebuffer window to 28x28 by averaging 8x8 blocks.
// Define DIGIT_SAMPLER_INVERT_EN to emit 255 minus the average (white-on-black digits).
module digit_sampler #(
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240,
  parameter int X0         = 48,
  parameter int Y0         = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [16:0] rdaddress,
  input  logic [7:0]  q,
  output logic [7:0]  pix_data,
  output logic [9:0]  pix_index,
  output logic        pix_valid,
  input  logic        pix_ready
);

  localparam int YW = $clog2(IMG_H);
  localparam int XW = $clog2(IMG_W);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, OUT, DONE} state_t;

  state_t                state;
  logic [4:0]            row;
  logic [4:0]            col;
  logic [5:0]            tap;
  logic [13:0]           acc;
  logic [RD_LATENCY-1:0] pend;
  logic [13:0]           rounded;
  logic [7:0]            pix_byte;
  logic [4:0]            next_row;
  logic [4:0]            next_col;
  logic                  last_block;

  // Tap k walks dx fastest (k[2:0]) then dy (k[5:3]) inside block (r,c).
  function automatic logic [16:0] tap_addr(input logic [4:0] r, input logic [4:0] c,
                                           input logic [5:0] k);
    logic [YW-1:0] y;
    logic [XW-1:0] x;
    y = YW'(Y0 + 8 * int'(r) + int'(k[5:3]));
    x = XW'(X0 + 8 * int'(c) + int'(k[2:0]));
    return 17'(int'(y) * IMG_W + int'(x));
  endfunction

  // A 64-sample sum never exceeds 16320, so the rounding add fits in 14 bits.
  assign rounded = acc + 14'd32;
`ifdef DIGIT_SAMPLER_INVERT_EN
  assign pix_byte = 8'd255 - rounded[13:6];
`else
  assign pix_byte = rounded[13:6];
`endif

  assign last_block = (row == 5'd27) && (col == 5'd27);
  assign next_col   = (col == 5'd27) ? 5'd0 : col + 5'd1;
  assign next_row   = (col == 5'd27) ? row + 5'd1 : row;

  // pend tracks which read slots are still in flight so each q is summed exactly once;
  // DRAIN leaves only after the last in-flight sample has landed in acc.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdaddress <= '0;
      pix_data  <= '0;
      pix_index <= '0;
      pix_valid <= 1'b0;
      row       <= '0;
      col       <= '0;
      tap       <= '0;
      acc       <= '0;
      pend      <= '0;
    end else begin
      pend[0] <= (state == READ);
      for (int i = 1; i < RD_LATENCY; i++) pend[i] <= pend[i-1];
      if (pend[RD_LATENCY-1]) acc <= acc + 14'(q);
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= READ;
            busy      <= 1'b1;
            acc       <= '0;
            row       <= '0;
            col       <= '0;
            tap       <= '0;
            rdaddress <= tap_addr(5'd0, 5'd0, 6'd0);
          end
        end
        READ: begin
          if (tap == 6'd63) begin
            state <= DRAIN;
          end else begin
            tap       <= tap + 6'd1;
            rdaddress <= tap_addr(row, col, tap + 6'd1);
          end
        end
        DRAIN: begin
          if (pend == '0) begin
            state     <= OUT;
            pix_valid <= 1'b1;
            pix_data  <= pix_byte;
            pix_index <= 10'(row) * 10'd28 + 10'(col);
          end
        end
        OUT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            acc       <= '0;
            if (last_block) begin
              state     <= DONE;
              done      <= 1'b1;
              rdaddress <= '0;
            end else begin
              state     <= READ;
              row       <= next_row;
              col       <= next_col;
              tap       <= '0;
              rdaddress <= tap_addr(next_row, next_col, 6'd0);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_sampler.sv
// Runs three digit_sampler instances (RD_LATENCY 2, 1, 4) concurrently against
// framebuffer models and an averaging reference model.
module tb_digit_sampler;

  localparam int IMG_W  = 320;
  localparam int X0     = 48;
  localparam int Y0     = 8;
  localparam int PIXELS = 784;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]       reset_v;
  logic [2:0]       start_v;
  logic [2:0]       ready_v;
  logic [2:0]       busy_v;
  logic [2:0]       done_v;
  logic [2:0]       valid_v;
  logic [2:0][16:0] addr_v;
  logic [2:0][7:0]  q_v;
  logic [2:0][7:0]  data_v;
  logic [2:0][9:0]  index_v;

  int mode_v [3];
  int seed_v [3];
  int test_count = 0;
  int fail_count = 0;

  digit_sampler #(.RD_LATENCY(2)) dut_a (
    .Clk(clock), .Reset(reset_v[0]), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .rdaddress(addr_v[0]), .q(q_v[0]), .pix_data(data_v[0]), .pix_index(index_v[0]),
    .pix_valid(valid_v[0]), .pix_ready(ready_v[0]));

  digit_sampler #(.RD_LATENCY(1)) dut_b (
    .Clk(clock), .Reset(reset_v[1]), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .rdaddress(addr_v[1]), .q(q_v[1]), .pix_data(data_v[1]), .pix_index(index_v[1]),
    .pix_valid(valid_v[1]), .pix_ready(ready_v[1]));

  digit_sampler #(.RD_LATENCY(4)) dut_c (
    .Clk(clock), .Reset(reset_v[2]), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .rdaddress(addr_v[2]), .q(q_v[2]), .pix_data(data_v[2]), .pix_index(index_v[2]),
    .pix_valid(valid_v[2]), .pix_ready(ready_v[2]));

  // Framebuffer contents: 0 = seeded pseudo-random, 1 = x & 0xFF, 2 = constant 37.
  function automatic logic [7:0] pixel_of(input int mode, input int seed, input int addr);
    int unsigned h;
    case (mode)
      1:       return 8'(addr % IMG_W);
      2:       return 8'd37;
      default: begin
        h = (unsigned'(addr) * 32'h9E3779B1) ^ unsigned'(seed);
        h = h ^ (h >> 15);
        return h[7:0];
      end
    endcase
  endfunction

  // Reference: rounded mean of the 8x8 block behind output pixel idx.
  function automatic int expected_pixel(input int mode, input int seed, input int idx);
    int r, c, sum, avg;
    r = idx / 28;
    c = idx % 28;
    case (mode)
      1:       avg = (52 + 8 * c) % 256;
      2:       avg = 37;
      default: begin
        sum = 0;
        for (int dy = 0; dy < 8; dy++)
          for (int dx = 0; dx < 8; dx++)
            sum += int'(pixel_of(0, seed, (Y0 + 8 * r + dy) * IMG_W + X0 + 8 * c + dx));
        avg = (sum + 32) / 64;
      end
    endcase
`ifdef DIGIT_SAMPLER_INVERT_EN
    avg = 255 - avg;
`endif
    return avg;
  endfunction

  // Read-latency models: data for an address appears RD_LATENCY cycles later.
  logic [7:0] pipe_a [2];
  logic [7:0] pipe_b;
  logic [7:0] pipe_c [4];
  always @(posedge clock) begin
    pipe_a[0] <= pixel_of(mode_v[0], seed_v[0], int'(addr_v[0]));
    pipe_a[1] <= pipe_a[0];
    pipe_b    <= pixel_of(mode_v[1], seed_v[1], int'(addr_v[1]));
    pipe_c[0] <= pixel_of(mode_v[2], seed_v[2], int'(addr_v[2]));
    for (int i = 1; i < 4; i++) pipe_c[i] <= pipe_c[i-1];
  end
  assign q_v[0] = pipe_a[1];
  assign q_v[1] = pipe_b;
  assign q_v[2] = pipe_c[3];

  function automatic string tag(input string name, input int u);
    return $sformatf("%s[u%0d]", name, u);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int u, input logic start_bit, input logic ready_bit);
    start_v[u] = start_bit;
    ready_v[u] = ready_bit;
  endtask

  task automatic check_idle(input int u, input string prefix);
    checkOutput(tag({prefix, "_busy"}, u), 32'(busy_v[u]), 0);
    checkOutput(tag({prefix, "_done"}, u), 32'(done_v[u]), 0);
    checkOutput(tag({prefix, "_valid"}, u), 32'(valid_v[u]), 0);
    checkOutput(tag({prefix, "_data"}, u), 32'(data_v[u]), 0);
    checkOutput(tag({prefix, "_index"}, u), 32'(index_v[u]), 0);
    checkOutput(tag({prefix, "_rdaddress"}, u), 32'(addr_v[u]), 0);
  endtask

  // Starts a frame on unit u (called at a negedge) and follows it pixel by pixel.
  // rel counts clock edges since the edge that accepted start.
  task automatic run_frame(input int u, input int lat, input int stall_at,
                           input int extra_start_at, input int abort_at, input bit random_ready);
    int got, dones, stall_left, tail, first_rel, abort_wait;
    bit stalled, finished, rdy;
    logic [7:0]  held_data;
    logic [9:0]  held_index;
    logic [16:0] held_addr;
    got = 0; dones = 0; stall_left = 0; tail = -1; first_rel = -1; abort_wait = 0;
    stalled = 0; finished = 0; held_data = '0; held_index = '0; held_addr = '0;
    applyStimulus(u, 1'b1, 1'b0);
    for (int rel = 0; rel < 70000 && !finished; rel++) begin
      @(negedge clock);
      if (rel == 0) checkOutput(tag("busy_after_start", u), 32'(busy_v[u]), 1);
      if (valid_v[u] && first_rel < 0) begin
        first_rel = rel;
        checkOutput(tag("first_valid_cycle", u), rel, 65 + lat);
      end
      if (done_v[u]) begin
        dones++;
        checkOutput(tag("pixels_before_done", u), got, PIXELS);
        if (tail < 0) tail = 3;
      end
      if (stall_left > 0) begin
        checkOutput(tag("stall_valid", u), 32'(valid_v[u]), 1);
        checkOutput(tag("stall_data", u), 32'(data_v[u]), 32'(held_data));
        checkOutput(tag("stall_index", u), 32'(index_v[u]), 32'(held_index));
        checkOutput(tag("stall_rdaddress", u), 32'(addr_v[u]), 32'(held_addr));
        stall_left--;
      end
      if (valid_v[u] && got == stall_at && !stalled) begin
        stalled    = 1;
        stall_left = 10;
        held_data  = data_v[u];
        held_index = index_v[u];
        held_addr  = addr_v[u];
      end
      rdy = (stall_left > 0) ? 1'b0 : (random_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (valid_v[u] && rdy) begin
        checkOutput(tag("pix_index", u), 32'(index_v[u]), got);
        checkOutput(tag("pix_data", u), 32'(data_v[u]), expected_pixel(mode_v[u], seed_v[u], got));
        checkOutput(tag("busy_in_out", u), 32'(busy_v[u]), 1);
        got++;
      end
      if (abort_at >= 0 && got == abort_at) begin
        abort_wait++;
        if (abort_wait == 20) finished = 1;
      end
      if (tail > 0) begin
        tail--;
        if (tail == 0) finished = 1;
      end
      applyStimulus(u, rel == extra_start_at - 1, rdy);
    end
    applyStimulus(u, 1'b0, 1'b0);
    checkOutput(tag("frame_reached_end", u), 32'(finished), 1);
    if (abort_at < 0) begin
      checkOutput(tag("pixel_count", u), got, PIXELS);
      checkOutput(tag("done_pulses", u), dones, 1);
      checkOutput(tag("busy_after_frame", u), 32'(busy_v[u]), 0);
    end else begin
      checkOutput(tag("no_done_before_abort", u), dones, 0);
    end
  endtask

  initial begin
    reset_v = '1;
    start_v = '0;
    ready_v = '0;
    mode_v[0] = 0; seed_v[0] = int'($urandom);
    mode_v[1] = 1; seed_v[1] = 0;
    mode_v[2] = 2; seed_v[2] = 0;
    repeat (3) @(negedge clock);
    for (int u = 0; u < 3; u++) check_idle(u, "reset_state");
    reset_v = '0;
    @(negedge clock);

    fork
      begin
        // Random image, random back-pressure, long stall on pixel 5, stray start at cycle 20.
        run_frame(0, 2, 5, 20, -1, 1'b1);
      end
      begin
        // Abandon a frame mid-read of pixel 300, then run the x & 0xFF frame to completion.
        run_frame(1, 1, -1, -1, 300, 1'b0);
        checkOutput("busy_before_reset[u1]", 32'(busy_v[1]), 1);
        reset_v[1] = 1'b1;
        #1;
        check_idle(1, "mid_frame_reset");
        for (int i = 0; i < 3; i++) begin
          @(negedge clock);
          checkOutput("no_done_in_reset[u1]", 32'(done_v[1]), 0);
        end
        reset_v[1] = 1'b0;
        @(negedge clock);
        run_frame(1, 1, -1, -1, -1, 1'b0);
      end
      begin
        // Constant frame at the deepest read latency.
        run_frame(2, 4, -1, -1, -1, 1'b0);
      end
    join

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
